// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants and the decoded-control bundle shared by the decode stage.
package mips_isa_pkg;

  localparam int OP_HI = 31, OP_LO = 26;
  localparam int RS_HI = 25, RS_LO = 21;
  localparam int RT_HI = 20, RT_LO = 16;
  localparam int RD_HI = 15, RD_LO = 11;
  localparam int SH_HI = 10, SH_LO = 6;
  localparam int FN_HI = 5,  FN_LO = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic        reg_write;
    logic        is_load;
    logic        is_store;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational instruction-word to control-bundle decode.
module mips_ctrl_decode
  import mips_isa_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o
);

  logic [5:0]  op;
  logic [15:0] imm16;

  assign op    = instr_i[OP_HI:OP_LO];
  assign imm16 = instr_i[15:0];

  always_comb begin
    ctrl_o        = '0;
    ctrl_o.opcode = op;
    ctrl_o.funct  = instr_i[FN_HI:FN_LO];
    ctrl_o.rs     = instr_i[RS_HI:RS_LO];
    ctrl_o.rt     = instr_i[RT_HI:RT_LO];
    ctrl_o.shamt  = instr_i[SH_HI:SH_LO];
    ctrl_o.imm    = (op == OP_ANDI || op == OP_ORI) ? {16'h0000, imm16}
                                                    : {{16{imm16[15]}}, imm16};
    case (op)
      OP_RTYPE: begin
        ctrl_o.dst       = instr_i[RD_HI:RD_LO];
        ctrl_o.reg_write = (instr_i[FN_HI:FN_LO] != FN_JR);
      end
      OP_LW: begin
        ctrl_o.dst       = instr_i[RT_HI:RT_LO];
        ctrl_o.is_load   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_SW:  ctrl_o.is_store = 1'b1;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        ctrl_o.dst       = instr_i[RT_HI:RT_LO];
        ctrl_o.reg_write = 1'b1;
      end
      OP_JAL: begin
        ctrl_o.dst       = REG_RA;
        ctrl_o.reg_write = 1'b1;
      end
      default: ;  // branches, J and unknown opcodes carry no writeback
    endcase
    if (ctrl_o.dst == REG_ZERO) ctrl_o.reg_write = 1'b0;
  end

endmodule

// File: rtl/mips_decode_stage.sv
// MIPS ID stage: fetch handshake, RF address drive, same-edge WB bypass,
// load-use stall and the ID/EX pipeline register.
module mips_decode_stage
  import mips_isa_pkg::*;
#(
  parameter int N     = 32,
  parameter int ASIZE = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [N-1:0]     if_instr,
  input  logic [N-1:0]     if_pc,
  output logic             if_ready,
  input  logic             flush,
  output logic [ASIZE-1:0] reg_id_r1,
  output logic [ASIZE-1:0] reg_id_r2,
  input  logic [N-1:0]     rf_data1,
  input  logic [N-1:0]     rf_data2,
  input  logic             wb_wr,
  input  logic [ASIZE-1:0] wb_reg_id,
  input  logic [N-1:0]     wb_data,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [N-1:0]     ex_pc,
  output logic [N-1:0]     ex_imm,
  output logic [N-1:0]     ex_op_a,
  output logic [N-1:0]     ex_op_b,
  output logic [5:0]       ex_opcode,
  output logic [5:0]       ex_funct,
  output logic [ASIZE-1:0] ex_rs,
  output logic [ASIZE-1:0] ex_rt,
  output logic [ASIZE-1:0] ex_dst,
  output logic [4:0]       ex_shamt,
  output logic             ex_reg_write,
  output logic             ex_is_load,
  output logic             ex_is_store
);

  ctrl_t            dec, ex_q;
  logic             ex_valid_q, ex_valid_d;
  logic [N-1:0]     pc_q, wb_q;
  logic             byp1_q, byp2_q;
  logic             adv, haz, take;
  logic [ASIZE-1:0] if_rs, if_rt;

  mips_ctrl_decode u_dec (
    .instr_i (if_instr),
    .ctrl_o  (dec)
  );

  assign if_rs = if_instr[RS_HI:RS_LO];
  assign if_rt = if_instr[RT_HI:RT_LO];

  assign adv = !ex_valid_q || ex_ready;
  assign haz = if_valid && ex_valid_q && ex_q.is_load && ex_q.rt != REG_ZERO &&
               (ex_q.rt == if_rs || ex_q.rt == if_rt);
  assign if_ready = !rst && adv && !haz;
  assign take     = !flush && adv && if_valid && !haz;

  // While stalled the held instruction's sources are re-read so late writebacks land.
  assign reg_id_r1 = adv ? if_rs : ex_q.rs;
  assign reg_id_r2 = adv ? if_rt : ex_q.rt;

  always_comb begin
    ex_valid_d = ex_valid_q;
    if (flush)    ex_valid_d = 1'b0;
    else if (adv) ex_valid_d = take;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
      pc_q       <= '0;
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      wb_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      if (take) begin
        ex_q <= dec;
        pc_q <= if_pc;
      end
      // RF returns pre-write data on a same-edge write; remember to substitute.
      byp1_q <= wb_wr && wb_reg_id == reg_id_r1 && reg_id_r1 != REG_ZERO;
      byp2_q <= wb_wr && wb_reg_id == reg_id_r2 && reg_id_r2 != REG_ZERO;
      wb_q   <= wb_data;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = pc_q;
  assign ex_imm       = ex_q.imm;
  assign ex_opcode    = ex_q.opcode;
  assign ex_funct     = ex_q.funct;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign ex_dst       = ex_q.dst;
  assign ex_shamt     = ex_q.shamt;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_is_load   = ex_q.is_load;
  assign ex_is_store  = ex_q.is_store;

  assign ex_op_a = (ex_q.rs == REG_ZERO) ? '0 : byp1_q ? wb_q : rf_data1;
  assign ex_op_b = (ex_q.rt == REG_ZERO) ? '0 : byp2_q ? wb_q : rf_data2;

endmodule

// File: tb/tb_mips_decode_stage.sv
// Bench for mips_decode_stage: behavioural RF + architectural model, directed and random stimulus.
module tb_mips_decode_stage;

  logic        clk = 1'b0;
  logic        rst, if_valid, if_ready, flush, wb_wr, ex_ready, ex_valid;
  logic [31:0] if_instr, if_pc, rf_data1, rf_data2, wb_data;
  logic [4:0]  reg_id_r1, reg_id_r2, wb_reg_id;
  logic [31:0] ex_pc, ex_imm, ex_op_a, ex_op_b;
  logic [5:0]  ex_opcode, ex_funct;
  logic [4:0]  ex_rs, ex_rt, ex_dst, ex_shamt;
  logic        ex_reg_write, ex_is_load, ex_is_store;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] regs [32];
  bit          mv;
  logic [31:0] minstr, mpc;

  always #5 clk = ~clk;

  mips_decode_stage #(.N(32), .ASIZE(5)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .flush(flush), .reg_id_r1(reg_id_r1), .reg_id_r2(reg_id_r2),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_wr(wb_wr), .wb_reg_id(wb_reg_id),
    .wb_data(wb_data), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_opcode(ex_opcode),
    .ex_funct(ex_funct), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_shamt(ex_shamt), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store)
  );

  // Register file: one-cycle registered read, old data on a same-edge write, r0 reads 0.
  always @(posedge clk) begin
    rf_data1 <= (reg_id_r1 == 5'd0) ? 32'd0 : regs[reg_id_r1];
    rf_data2 <= (reg_id_r2 == 5'd0) ? 32'd0 : regs[reg_id_r2];
    if (wb_wr && wb_reg_id != 5'd0) regs[wb_reg_id] <= wb_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction semantics straight from the ISA table.
  function automatic void ref_decode(input logic [31:0] i, output logic [4:0] dst,
                                     output logic rw, output logic ld, output logic st,
                                     output logic [31:0] imm);
    logic [5:0] op;
    op  = i[31:26];
    imm = (op == 6'h0C || op == 6'h0D) ? {16'h0, i[15:0]} : {{16{i[15]}}, i[15:0]};
    dst = 5'd0; rw = 1'b0; ld = 1'b0; st = 1'b0;
    if (op == 6'h00) begin dst = i[15:11]; rw = (i[5:0] != 6'h08); end
    else if (op == 6'h23) begin dst = i[20:16]; rw = 1'b1; ld = 1'b1; end
    else if (op == 6'h2B) st = 1'b1;
    else if (op == 6'h08 || op == 6'h0A || op == 6'h0C || op == 6'h0D || op == 6'h0F)
      begin dst = i[20:16]; rw = 1'b1; end
    else if (op == 6'h03) begin dst = 5'd31; rw = 1'b1; end
    if (dst == 5'd0) rw = 1'b0;
  endfunction

  function automatic bit ref_haz(input bit v, input logic [31:0] held, input bit iv,
                                 input logic [31:0] ins);
    logic [4:0] d; logic rw, ld, st; logic [31:0] im;
    ref_decode(held, d, rw, ld, st, im);
    return iv && v && ld && held[20:16] != 5'd0 &&
           (held[20:16] == ins[25:21] || held[20:16] == ins[20:16]);
  endfunction

  // Model of what sits in ID/EX: the accepted instruction word plus its PC.
  always @(posedge clk) begin
    if (rst) begin
      mv = 1'b0; minstr = 32'd0; mpc = 32'd0;
    end else if (flush) begin
      mv = 1'b0;
    end else if (!mv || ex_ready) begin
      if (if_valid && !ref_haz(mv, minstr, if_valid, if_instr)) begin
        mv = 1'b1; minstr = if_instr; mpc = if_pc;
      end else mv = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [4:0] d; logic rw, ld, st; logic [31:0] im;
      bit m_adv, m_haz;
      ref_decode(minstr, d, rw, ld, st, im);
      m_adv = !mv || ex_ready;
      m_haz = ref_haz(mv, minstr, if_valid, if_instr);
      chk("if_ready", 32'(if_ready), 32'(!rst && m_adv && !m_haz));
      chk("reg_id_r1", 32'(reg_id_r1), 32'(m_adv ? if_instr[25:21] : minstr[25:21]));
      chk("reg_id_r2", 32'(reg_id_r2), 32'(m_adv ? if_instr[20:16] : minstr[20:16]));
      chk("ex_valid", 32'(ex_valid), 32'(mv));
      chk("ex_pc", ex_pc, mpc);
      chk("ex_imm", ex_imm, im);
      chk("ex_opcode", 32'(ex_opcode), 32'(minstr[31:26]));
      chk("ex_funct", 32'(ex_funct), 32'(minstr[5:0]));
      chk("ex_rs", 32'(ex_rs), 32'(minstr[25:21]));
      chk("ex_rt", 32'(ex_rt), 32'(minstr[20:16]));
      chk("ex_shamt", 32'(ex_shamt), 32'(minstr[10:6]));
      chk("ex_dst", 32'(ex_dst), 32'(d));
      chk("ex_flags", 32'({ex_reg_write, ex_is_load, ex_is_store}), 32'({rw, ld, st}));
      if (mv) begin
        // Operands must equal the architectural register value after the latest write.
        chk("ex_op_a", ex_op_a, (minstr[25:21] == 5'd0) ? 32'd0 : regs[minstr[25:21]]);
        chk("ex_op_b", ex_op_b, (minstr[20:16] == 5'd0) ? 32'd0 : regs[minstr[20:16]]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic [15:0] lo;
    case ($urandom_range(0, 12))
      0, 1: op = 6'h00;  1+1: op = 6'h23;  3: op = 6'h2B;  4: op = 6'h08;
      5: op = 6'h0A;  6: op = 6'h0C;  7: op = 6'h0D;  8: op = 6'h0F;
      9: op = 6'h04;  10: op = 6'h03;  11: op = 6'h02;  default: op = 6'h3F;
    endcase
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    lo = 16'($urandom);
    if (op == 6'h00)
      lo = {rd, lo[10:6], ($urandom_range(0, 3) == 0) ? 6'h08 : lo[5:0]};
    return {op, rs, rt, lo};
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1; if_valid = 1'b1;
    if_instr = enc_r(3, 4, 5); if_pc = 32'h100;
    wb_wr = 1'b0; wb_reg_id = 5'd0; wb_data = 32'd0;
    // Preload r_i = i through the writeback port while reset holds the stage.
    for (int i = 1; i < 32; i++) begin
      wb_wr = 1'b1; wb_reg_id = 5'(i); wb_data = 32'(i);
      cyc();
      chk_en = 1'b1;
    end
    #1;
    chk("rst ex_valid", 32'(ex_valid), 32'd0);
    chk("rst ex_op_a", ex_op_a, 32'd0);
    chk("rst if_ready", 32'(if_ready), 32'd0);
    rst = 1'b0; wb_wr = 1'b0; if_valid = 1'b0;
    #1;
    chk("post-rst if_ready", 32'(if_ready), 32'd1);

    if_valid = 1'b1; if_instr = enc_r(3, 4, 5); if_pc = 32'h200;
    cyc(); if_valid = 1'b0; #1;
    chk("add ex_valid", 32'(ex_valid), 32'd1);
    chk("add op_a", ex_op_a, 32'd3);
    chk("add op_b", ex_op_b, 32'd4);
    chk("add dst", 32'(ex_dst), 32'd5);
    chk("add reg_write", 32'(ex_reg_write), 32'd1);
    chk("add pc", ex_pc, 32'h200);

    if_valid = 1'b1; wb_wr = 1'b1; wb_reg_id = 5'd3; wb_data = 32'h55;
    cyc(); wb_wr = 1'b0; if_valid = 1'b0; #1;
    chk("byp op_a", ex_op_a, 32'h55);
    chk("byp op_b", ex_op_b, 32'd4);

    if_valid = 1'b1; wb_wr = 1'b1; wb_reg_id = 5'd0; wb_data = 32'h77;
    cyc(); wb_wr = 1'b0; if_valid = 1'b0; #1;
    chk("r0 nobyp op_a", ex_op_a, 32'h55);
    chk("r0 nobyp op_b", ex_op_b, 32'd4);

    if_valid = 1'b1; if_instr = {6'h23, 5'd1, 5'd2, 16'h0000};
    cyc(); if_instr = enc_r(2, 3, 6); #1;
    chk("lu if_ready", 32'(if_ready), 32'd0);
    chk("lu is_load", 32'(ex_is_load), 32'd1);
    cyc(); #1;
    chk("lu bubble", 32'(ex_valid), 32'd0);
    chk("lu if_ready2", 32'(if_ready), 32'd1);
    cyc(); if_valid = 1'b0; #1;
    chk("lu ex_valid", 32'(ex_valid), 32'd1);
    chk("lu ex_rs", 32'(ex_rs), 32'd2);
    chk("lu op_a", ex_op_a, 32'd2);

    if_valid = 1'b1; if_instr = enc_r(3, 4, 5);
    cyc();
    ex_ready = 1'b0; if_instr = enc_r(1, 2, 8);
    wb_wr = 1'b1; wb_reg_id = 5'd4; wb_data = 32'h99; #1;
    chk("stall if_ready0", 32'(if_ready), 32'd0);
    chk("stall op_b0", ex_op_b, 32'd4);
    cyc(); wb_wr = 1'b0; #1;
    chk("stall op_b1", ex_op_b, 32'h99);
    chk("stall dst", 32'(ex_dst), 32'd5);
    chk("stall op_a", ex_op_a, 32'h55);
    chk("stall if_ready1", 32'(if_ready), 32'd0);
    cyc(); #1;
    chk("stall op_b2", ex_op_b, 32'h99);
    chk("stall valid", 32'(ex_valid), 32'd1);
    flush = 1'b1;
    cyc(); flush = 1'b0; #1;
    chk("flush stall valid", 32'(ex_valid), 32'd0);

    ex_ready = 1'b1; if_instr = {6'h08, 5'd0, 5'd7, 16'hFFFF};
    cyc(); #1;
    chk("addi imm", ex_imm, 32'hFFFF_FFFF);
    chk("addi dst", 32'(ex_dst), 32'd7);
    if_instr = {6'h0D, 5'd0, 5'd7, 16'hFFFF};
    cyc(); if_valid = 1'b0; #1;
    chk("ori imm", ex_imm, 32'h0000_FFFF);

    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      ex_ready  = ($urandom_range(0, 9) < 7);
      if_valid  = ($urandom_range(0, 9) < 8);
      if_instr  = rand_instr();
      if_pc     = $urandom;
      wb_wr     = ($urandom_range(0, 1) == 1);
      wb_reg_id = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
